// File: rtl/crtc_config_sequencer_if.sv
// Bus bundle for the CRTC config sequencer: host-side CRTC pins and requests in,
// CRTC-side pins and status out. The sequencer itself uses the slave modport.
interface crtc_config_sequencer_if;
    logic       START;
    logic [1:0] MODE;
    logic       H_CSn, H_RS, H_RW, H_E;
    logic [7:0] H_D;
    logic       CSn, RS, RW, E;
    logic [7:0] D;
    logic       BUSY, DONE, H_WAIT;

    modport slave (
        input  START, MODE, H_CSn, H_RS, H_RW, H_E, H_D,
        output CSn, RS, RW, E, D, BUSY, DONE, H_WAIT
    );

    modport master (
        output START, MODE, H_CSn, H_RS, H_RW, H_E, H_D,
        input  CSn, RS, RW, E, D, BUSY, DONE, H_WAIT
    );
endinterface

// File: rtl/crtc_config_sequencer.sv
// Writes a preset CRTC register table (R0..LAST_REG) over the 6845-style bus,
// taking the bus from the host only between its own cycles.
module crtc_config_sequencer #(
    parameter int AUTO_INIT = 1,
    parameter int LAST_REG  = 15
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    crtc_config_sequencer_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = (LAST_REG > 15) ? 4'd15 : 4'(LAST_REG);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_HOST = 3'd1;
    localparam logic [2:0] S_ADDR      = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_FINISH    = 3'd4;

    // Rows hold R0 in the most significant byte; R12..R15 are always zero.
    localparam logic [95:0] ROW0 = 96'h61_50_52_0F_19_06_19_19_02_0D_0B_0C;
    localparam logic [95:0] ROW1 = 96'h71_50_5A_0A_1F_06_19_1C_02_07_06_07;
    localparam logic [95:0] ROW2 = 96'h38_28_2D_0A_1F_06_19_1C_02_07_06_07;
    localparam logic [95:0] ROW3 = 96'h38_28_2D_0A_7F_06_64_70_02_01_06_07;
    localparam logic [3:0][95:0] TBL = {ROW3, ROW2, ROW1, ROW0};

    function automatic logic [7:0] table_byte(input logic [1:0] mode, input logic [3:0] idx);
        logic [95:0] row;
        logic [7:0]  b;
        row = TBL[mode];
        b   = 8'h00;
        for (int i = 0; i < 12; i++)
            if (idx == 4'(i)) b = row[8*(11-i) +: 8];
        return b;
    endfunction

    logic [2:0] state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [1:0] phase_q, phase_d;
    logic [1:0] mode_q, mode_d;
    logic       auto_q, auto_d;

    logic       busy;
    logic       csn, rs, rw, e;
    logic [7:0] d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        mode_d  = mode_q;
        auto_d  = auto_q;
        case (state_q)
            S_IDLE: begin
                if (bus.START || auto_q) begin
                    mode_d  = bus.MODE;
                    idx_d   = 4'd0;
                    phase_d = 2'd0;
                    auto_d  = 1'b0;
                    state_d = bus.H_CSn ? S_ADDR : S_WAIT_HOST;
                end
            end
            S_WAIT_HOST: begin
                if (bus.H_CSn) begin
                    phase_d = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) state_d = S_DATA;
            end
            S_DATA: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // auto_q arms the one-shot sequence that follows reset release.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            phase_q <= 2'd0;
            mode_q  <= 2'd0;
            auto_q  <= (AUTO_INIT != 0);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            auto_q  <= auto_d;
        end
    end

    assign busy = (state_q == S_ADDR) || (state_q == S_DATA);

    // E is high in P1/P2 only, so RS/D are settled a full CLK around its falling edge.
    always_comb begin
        csn = bus.H_CSn;
        rs  = bus.H_RS;
        rw  = bus.H_RW;
        e   = bus.H_E;
        d   = bus.H_D;
        if (busy) begin
            csn = 1'b0;
            rw  = 1'b0;
            rs  = (state_q == S_DATA);
            d   = (state_q == S_DATA) ? table_byte(mode_q, idx_q) : {4'b0000, idx_q};
            e   = (phase_q == 2'd1) || (phase_q == 2'd2);
        end else if (state_q == S_FINISH) begin
            csn = 1'b1;
            e   = 1'b0;
        end
    end

    assign bus.CSn    = csn;
    assign bus.RS     = rs;
    assign bus.RW     = rw;
    assign bus.E      = e;
    assign bus.D      = d;
    assign bus.BUSY   = busy;
    assign bus.DONE   = (state_q == S_FINISH);
    assign bus.H_WAIT = busy || (state_q == S_WAIT_HOST);

endmodule

// File: tb/tb_crtc_config_sequencer.sv
// Bench for crtc_config_sequencer: an auto-init instance checked every cycle against a
// cycle-count model, plus a manual-start instance checked through captured register writes.
module tb_crtc_config_sequencer;

    logic clk = 1'b0;
    logic rstn_a, rstn_m;
    logic chk_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    crtc_config_sequencer_if a_if ();
    crtc_config_sequencer_if m_if ();

    crtc_config_sequencer #(.AUTO_INIT(1), .LAST_REG(15)) u_dut_auto (
        .CLK (clk),
        .RSTn(rstn_a),
        .bus (a_if)
    );

    crtc_config_sequencer #(.AUTO_INIT(0), .LAST_REG(15)) u_dut_man (
        .CLK (clk),
        .RSTn(rstn_m),
        .bus (m_if)
    );

    logic [7:0] tbl [4][16] = '{
        '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19,
          8'h02, 8'h0D, 8'h0B, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h71, 8'h50, 8'h5A, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
          8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h1F, 8'h06, 8'h19, 8'h1C,
          8'h02, 8'h07, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h38, 8'h28, 8'h2D, 8'h0A, 8'h7F, 8'h06, 8'h64, 8'h70,
          8'h02, 8'h01, 8'h06, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a sequence is a run of 128 cycles indexed by k; register k/8, ADDR half then DATA half.
    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_RUN  = 2;
    localparam int M_FIN  = 3;

    int         m_state   = M_IDLE;
    int         m_k       = 0;
    logic [1:0] m_mode    = 2'd0;
    logic       m_pending = 1'b1;

    always @(posedge clk or negedge rstn_a) begin
        if (!rstn_a) begin
            m_state   <= M_IDLE;
            m_k       <= 0;
            m_mode    <= 2'd0;
            m_pending <= 1'b1;
        end else begin
            case (m_state)
                M_IDLE: if (a_if.START || m_pending) begin
                    m_pending <= 1'b0;
                    m_mode    <= a_if.MODE;
                    m_k       <= 0;
                    m_state   <= a_if.H_CSn ? M_RUN : M_WAIT;
                end
                M_WAIT: if (a_if.H_CSn) begin
                    m_k     <= 0;
                    m_state <= M_RUN;
                end
                M_RUN: begin
                    m_k <= m_k + 1;
                    if (m_k == 127) m_state <= M_FIN;
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    function automatic logic [14:0] model_out();
        logic       csn, rs, rw, e, busy, done, hwait;
        logic [7:0] d;
        int         r, w;
        csn = a_if.H_CSn; rs = a_if.H_RS; rw = a_if.H_RW; e = a_if.H_E; d = a_if.H_D;
        busy = 1'b0; done = 1'b0; hwait = 1'b0;
        case (m_state)
            M_WAIT: hwait = 1'b1;
            M_RUN: begin
                r = m_k / 8;
                w = m_k % 8;
                csn = 1'b0; rw = 1'b0;
                rs  = (w >= 4);
                e   = ((w % 4) == 1) || ((w % 4) == 2);
                d   = rs ? tbl[m_mode][r] : 8'(r);
                busy = 1'b1; hwait = 1'b1;
            end
            M_FIN: begin
                csn = 1'b1; e = 1'b0; done = 1'b1;
            end
            default: ;
        endcase
        return {csn, rs, rw, e, d, busy, done, hwait};
    endfunction

    always @(negedge clk) begin
        if (chk_en)
            check_output("cycle",
                16'({a_if.CSn, a_if.RS, a_if.RW, a_if.E, a_if.D, a_if.BUSY, a_if.DONE, a_if.H_WAIT}),
                16'(model_out()));
    end

    // Emulated CRTC register files: latch address on RS=0, write data on RS=1, at E falling edges.
    logic [7:0] cap_a [16] = '{default: 8'hEE};
    logic [7:0] cap_m [16] = '{default: 8'hEE};
    logic [3:0] cap_a_addr = 4'd0;
    logic [3:0] cap_m_addr = 4'd0;
    int         falls_a = 0;
    int         falls_m = 0;
    int         addr_log_a [$];

    always @(negedge a_if.E) begin
        if (a_if.BUSY) begin
            if (!a_if.RS) begin
                cap_a_addr = a_if.D[3:0];
                addr_log_a.push_back(int'(a_if.D));
            end else begin
                cap_a[cap_a_addr] = a_if.D;
            end
            falls_a++;
        end
    end

    always @(negedge m_if.E) begin
        if (m_if.BUSY) begin
            if (!m_if.RS) cap_m_addr = m_if.D[3:0];
            else          cap_m[cap_m_addr] = m_if.D;
            falls_m++;
        end
    end

    task automatic apply_stimulus(input logic start, input logic [1:0] mode, input logic h_csn,
                                  input logic h_rs, input logic h_rw, input logic h_e,
                                  input logic [7:0] h_d);
        @(posedge clk);
        #2;
        a_if.START = start;
        a_if.MODE  = mode;
        a_if.H_CSn = h_csn;
        a_if.H_RS  = h_rs;
        a_if.H_RW  = h_rw;
        a_if.H_E   = h_e;
        a_if.H_D   = h_d;
    endtask

    task automatic run_until_done(input bit man, input int limit,
                                  output int busy_cycles, output int start_to_done);
        int   first;
        logic bz, dn;
        first = -1;
        busy_cycles = 0;
        start_to_done = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            bz = man ? m_if.BUSY : a_if.BUSY;
            dn = man ? m_if.DONE : a_if.DONE;
            if (bz) begin
                busy_cycles++;
                if (first < 0) first = n;
            end
            if (dn) begin
                start_to_done = n - first;
                break;
            end
        end
        if (start_to_done < 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL done_timeout: no DONE within %0d cycles", limit);
        end
    endtask

    task automatic check_regs_a(input int m, input string tag);
        for (int i = 0; i < 16; i++)
            check_output($sformatf("%s_R%0d", tag, i), 16'(cap_a[i]), 16'(tbl[m][i]));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bc, sd, base, log_base;

        a_if.START = 1'b0; a_if.MODE = 2'd0; a_if.H_CSn = 1'b1; a_if.H_RS = 1'b0;
        a_if.H_RW = 1'b0; a_if.H_E = 1'b0; a_if.H_D = 8'h00;
        m_if.START = 1'b0; m_if.MODE = 2'd0; m_if.H_CSn = 1'b1; m_if.H_RS = 1'b0;
        m_if.H_RW = 1'b0; m_if.H_E = 1'b0; m_if.H_D = 8'h00;
        rstn_a = 1'b0;
        rstn_m = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;

        $display("[TB] reset state and pass-through");
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5);
        @(negedge clk);
        check_output("rst_busy",  16'(a_if.BUSY),   16'h0);
        check_output("rst_done",  16'(a_if.DONE),   16'h0);
        check_output("rst_hwait", 16'(a_if.H_WAIT), 16'h0);
        check_output("rst_d",     16'(a_if.D),      16'h00A5);
        check_output("rst_e",     16'(a_if.E),      16'h1);

        $display("[TB] auto-init sequence, MODE0");
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        base = falls_a;
        log_base = addr_log_a.size();
        rstn_a = 1'b1;
        run_until_done(1'b0, 300, bc, sd);
        check_output("auto_busy_cycles", 16'(bc), 16'd128);
        check_output("auto_start_to_done", 16'(sd), 16'd128);
        check_output("auto_e_falls", 16'(falls_a - base), 16'd32);
        check_output("auto_first_addr",
                     16'((addr_log_a.size() > log_base) ? addr_log_a[log_base] : -1), 16'd0);
        check_output("auto_R0_lit", 16'(cap_a[0]), 16'h61);
        check_output("auto_R1_lit", 16'(cap_a[1]), 16'h50);
        check_output("auto_R9_lit", 16'(cap_a[9]), 16'h0D);
        check_output("auto_R15_lit", 16'(cap_a[15]), 16'h00);
        check_regs_a(0, "auto");
        @(negedge clk);
        check_output("auto_done_width", 16'(a_if.DONE), 16'h0);

        $display("[TB] START while host holds the bus");
        base = falls_a;
        apply_stimulus(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (9) @(negedge clk);
        check_output("wait_hwait", 16'(a_if.H_WAIT), 16'h1);
        check_output("wait_busy", 16'(a_if.BUSY), 16'h0);
        check_output("wait_no_e", 16'(falls_a - base), 16'd0);
        apply_stimulus(1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        run_until_done(1'b0, 300, bc, sd);
        check_output("wait_busy_cycles", 16'(bc), 16'd128);
        check_output("wait_e_falls", 16'(falls_a - base), 16'd32);
        check_output("wait_R4_lit", 16'(cap_a[4]), 16'h7F);

        $display("[TB] MODE change and START mid-sequence");
        base = falls_a;
        apply_stimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (37) @(posedge clk);
        apply_stimulus(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        run_until_done(1'b0, 300, bc, sd);
        apply_stimulus(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) @(negedge clk);
        check_output("midseq_no_restart", 16'(a_if.BUSY), 16'h0);
        check_output("midseq_e_falls", 16'(falls_a - base), 16'd32);
        check_output("midseq_R0_lit", 16'(cap_a[0]), 16'h71);
        check_output("midseq_R2_lit", 16'(cap_a[2]), 16'h5A);
        check_regs_a(1, "midseq");

        $display("[TB] reset abort mid-sequence");
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        rstn_a = 1'b0;
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        rstn_a = 1'b1;
        repeat (50) @(posedge clk);
        #2;
        rstn_a = 1'b0;
        #1;
        check_output("abort_busy", 16'(a_if.BUSY), 16'h0);
        check_output("abort_e", 16'(a_if.E), 16'h0);
        base = falls_a;
        repeat (3) @(negedge clk);
        check_output("abort_no_e", 16'(falls_a - base), 16'd0);
        log_base = addr_log_a.size();
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        rstn_a = 1'b1;
        run_until_done(1'b0, 300, bc, sd);
        check_output("abort_first_addr",
                     16'((addr_log_a.size() > log_base) ? addr_log_a[log_base] : -1), 16'd0);
        check_output("abort_e_falls", 16'(falls_a - base), 16'd32);
        check_output("abort_R3_lit", 16'(cap_a[3]), 16'h0F);
        check_regs_a(0, "abort");

        $display("[TB] idle host pass-through");
        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A);
        @(negedge clk);
        check_output("pass_addr_csn", 16'(a_if.CSn), 16'h0);
        check_output("pass_addr_rs", 16'(a_if.RS), 16'h0);
        check_output("pass_addr_e", 16'(a_if.E), 16'h1);
        check_output("pass_addr_d", 16'(a_if.D), 16'h000A);
        apply_stimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
        @(negedge clk);
        check_output("pass_data_rs", 16'(a_if.RS), 16'h1);
        check_output("pass_data_d", 16'(a_if.D), 16'h0020);
        check_output("pass_busy", 16'(a_if.BUSY), 16'h0);
        check_output("pass_done", 16'(a_if.DONE), 16'h0);
        apply_stimulus(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        $display("[TB] manual-start instance, MODE3");
        @(posedge clk);
        #2;
        m_if.MODE = 2'd3;
        rstn_m = 1'b1;
        repeat (5) @(negedge clk);
        check_output("man_no_auto_busy", 16'(m_if.BUSY), 16'h0);
        check_output("man_no_auto_hwait", 16'(m_if.H_WAIT), 16'h0);
        @(posedge clk);
        #2;
        m_if.START = 1'b1;
        @(posedge clk);
        #2;
        m_if.START = 1'b0;
        m_if.MODE  = 2'd0;
        run_until_done(1'b1, 300, bc, sd);
        check_output("man_busy_cycles", 16'(bc), 16'd128);
        check_output("man_e_falls", 16'(falls_m), 16'd32);
        check_output("man_R4_lit", 16'(cap_m[4]), 16'h7F);
        check_output("man_R6_lit", 16'(cap_m[6]), 16'h64);
        check_output("man_R7_lit", 16'(cap_m[7]), 16'h70);
        check_output("man_R9_lit", 16'(cap_m[9]), 16'h01);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/crtc_config_sequencer.md
CRTC_CONFIG_SEQUENCER -- requirements
Module: crtc_config_sequencer

Interface
REQ-001 Parameter: AUTO_INIT, default 1, 1 = start a sequence automatically after reset release.
REQ-002 Parameter: LAST_REG, default 15, highest CRTC register index written (sequence writes R0..LAST_REG).
REQ-003 CLK  input  1  character/system clock; all state on posedge.
REQ-004 RSTn  input  1  reset, asynchronous, active-low.
REQ-005 START  input  1  request a programming sequence, level-sampled in IDLE.
REQ-006 MODE  input  2  preset table select, sampled when a sequence is accepted.
REQ-007 H_CSn, H_RS, H_RW, H_E  input  1 each  host CRTC bus controls.
REQ-008 H_D  input  8  host write data.
REQ-009 CSn, RS, RW, E  output  1 each  CRTC bus controls.
REQ-010 D  output  8  CRTC write data.
REQ-011 BUSY  output  1  sequencer owns CRTC bus.
REQ-012 DONE  output  1  one-CLK pulse at sequence completion.
REQ-013 H_WAIT  output  1  host must hold off; high while BUSY or while a sequence is pending.

Function
REQ-014 The block SHALL implement states IDLE, WAIT_HOST, ADDR, DATA, FINISH.
REQ-015 In IDLE with START=1 (or the first clock after reset when AUTO_INIT=1), the block SHALL latch MODE, clear the register index, and go to ADDR if H_CSn=1, else WAIT_HOST.
REQ-016 WAIT_HOST SHALL hold H_WAIT=1 and move to ADDR on the first clock with H_CSn=1.
REQ-017 Each ADDR or DATA bus cycle SHALL last exactly 4 CLKs, phases P0..P3 from a 2-bit counter.
REQ-018 During all phases: CSn=0, RW=0; RS=0 in ADDR, 1 in DATA; D = index (zero-extended) in ADDR, table byte in DATA.
REQ-019 E SHALL be 0 in P0, 1 in P1 and P2, and 0 in P3, giving one falling edge per bus cycle at the P2->P3 boundary with D/RS stable one CLK before and after.
REQ-020 After DATA P3, if index = LAST_REG go to FINISH, else increment index (4-bit) and go to ADDR.
REQ-021 FINISH SHALL last one CLK with DONE=1 and BUSY=0, CSn=1, E=0, then return to IDLE.
REQ-022 BUSY SHALL be 1 in ADDR and DATA only; a sequence occupies 8*(LAST_REG+1) CLKs (128 at default).
REQ-023 In IDLE, WAIT_HOST and FINISH, CSn/RS/RW/E/D SHALL combinationally follow H_CSn/H_RS/H_RW/H_E/H_D, except that FINISH forces CSn=1 and E=0.
REQ-024 START while BUSY, WAIT_HOST or FINISH SHALL be ignored; MODE changes mid-sequence SHALL have no effect.
REQ-025 Table rows R0..R11 (R12..R15 = 0x00 for all modes):
  MODE0 MDA 80x25: 61 50 52 0F 19 06 19 19 02 0D 0B 0C
  MODE1 CGA 80x25: 71 50 5A 0A 1F 06 19 1C 02 07 06 07
  MODE2 CGA 40x25: 38 28 2D 0A 1F 06 19 1C 02 07 06 07
  MODE3 CGA gfx: 38 28 2D 0A 7F 06 64 70 02 01 06 07
REQ-026 Indices above 15 SHALL NOT be generated; LAST_REG > 15 SHALL be treated as 15.

Reset
REQ-027 With RSTn=0: state IDLE, index 0, phase 0, latched mode 0, BUSY=0, DONE=0, H_WAIT=0, and CRTC outputs passed through from the host.
REQ-028 RSTn asserted mid-sequence SHALL abort immediately, with no further E edges from the sequencer; with AUTO_INIT=1 a full new sequence starts after release.
REQ-029 When AUTO_INIT=1, H_WAIT SHALL be 1 from the first clock after RSTn release until FINISH.

Verification
REQ-030 AUTO_INIT=1, MODE=0, H_CSn=1, release reset -> 32 E falling edges; captured register pairs (0,61),(1,50)...(9,0D),(15,00); one DONE pulse 128 CLKs after start.
REQ-031 AUTO_INIT=0, MODE=3, START pulse -> R4=7F, R6=64, R7=70, R9=01; BUSY high exactly 128 CLKs.
REQ-032 START while H_CSn=0 for 10 CLKs -> H_WAIT=1, no sequencer E edge until H_CSn=1; sequence then completes normally.
REQ-033 MODE toggled 1->2 at CLK 40 of a MODE1 sequence, plus START re-asserted -> all bytes from MODE1 table; no second sequence started.
REQ-034 RSTn low at CLK 50 (AUTO_INIT=1) -> BUSY=0 and E=0 immediately; after release, writes restart at R0.
REQ-035 Idle pass-through: host write addr 0x0A then data 0x20 -> CRTC pins mirror host pins; BUSY=0, DONE=0.
